// File: rtl/core_types_pkg.sv
// ============================================================================
// Module      : core_types_pkg
// Description : Shared core widths and typedefs for PR tags and PRF banks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_types_pkg;

    localparam int LOG_PR_COUNT          = 7;
    localparam int PRF_BANK_COUNT        = 4;
    localparam int LOG_PRF_BANK_COUNT    = 2;
    localparam int ROB_PR_FREE_WAYS      = 4;
    localparam int ROB_PR_FREE_Q_ENTRIES = 2;

    typedef logic [LOG_PR_COUNT-1:0]       pr_t;
    typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;

endpackage

`default_nettype wire

// File: rtl/rob_pr_free_bank_q.sv
// ============================================================================
// Module      : rob_pr_free_bank_q
// Description : Single-bank PR FIFO with wrapping head/tail pointers and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_pr_free_bank_q #(
    parameter int DEPTH = 2,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_enq,
    input  logic [W-1:0] i_enq_data,
    input  logic         i_deq,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_enq;
    logic             w_deq;

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == c_last_ptr) ? '0 : p + PTR_W'(1);
    endfunction

    // Full is judged on the registered count, so a same-cycle dequeue never frees a slot.
    assign o_full  = (r_count == c_depth);
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_head] : '0;
    assign w_enq   = i_enq & ~o_full;
    assign w_deq   = i_deq & o_valid;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= i_enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= f_next_ptr(r_tail);
            end
            if (w_deq) begin
                r_head <= f_next_ptr(r_head);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rob_pr_free_q.sv
// ============================================================================
// Module      : rob_pr_free_q
// Description : Steers PRs freed at ROB commit into per-bank FIFOs feeding the
//               banked free list. Optional same-cycle bypass when
//               ROB_PR_FREE_Q_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_pr_free_q
    import core_types_pkg::*;
#(
    parameter int WAYS      = ROB_PR_FREE_WAYS,
    parameter int BANKS     = PRF_BANK_COUNT,
    parameter int Q_ENTRIES = ROB_PR_FREE_Q_ENTRIES,
    parameter int PR_W      = LOG_PR_COUNT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WAYS-1:0]       commit_free_valid_by_way,
    input  logic [WAYS*PR_W-1:0]  commit_free_PR_by_way,
    output logic                  commit_free_ready,
    output logic [BANKS-1:0]      free_q_valid_by_bank,
    output logic [BANKS*PR_W-1:0] free_q_PR_by_bank,
    input  logic [BANKS-1:0]      free_list_ready_by_bank
);

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic [PR_W-1:0]              r_pr [WAYS];
    logic [WAYS-1:0]              r_pend;
    logic [WAYS-1:0]              w_moved;
    logic [WAYS-1:0]              w_pend_next;
    logic [BANKS-1:0][WAYS-1:0]   w_lane_take;
    logic                         w_accept;

    genvar b;
    generate
        for (b = 0; b < BANKS; b++) begin : g_bank
            logic [WAYS-1:0] w_hit;
            logic [WAYS-1:0] w_onehot;
            logic [PR_W-1:0] w_sel_pr;
            logic [PR_W-1:0] w_fifo_pr;
            logic            w_sel_valid;
            logic            w_take;
            logic            w_enq;
            logic            w_fifo_valid;
            logic            w_fifo_full;

            always_comb begin
                w_hit = '0;
                for (int w = 0; w < WAYS; w++) begin
                    w_hit[w] = r_pend[w] && (r_pr[w][BANK_W-1:0] == BANK_W'(b));
                end
            end

            // Isolate the lowest set bit: lowest-index lane wins this bank.
            assign w_onehot    = w_hit & (~w_hit + WAYS'(1));
            assign w_sel_valid = |w_hit;

            always_comb begin
                w_sel_pr = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (w_onehot[w]) begin
                        w_sel_pr = w_sel_pr | r_pr[w];
                    end
                end
            end

            assign w_take         = w_sel_valid & ~w_fifo_full;
            assign w_lane_take[b] = w_take ? w_onehot : '0;

`ifdef ROB_PR_FREE_Q_BYPASS_EN
            logic w_bypass;
            assign w_bypass = w_sel_valid & ~w_fifo_valid;
            assign w_enq    = w_take & ~(w_bypass & free_list_ready_by_bank[b]);
            assign free_q_valid_by_bank[b]             = w_fifo_valid | w_bypass;
            assign free_q_PR_by_bank[b*PR_W +: PR_W]   = w_bypass ? w_sel_pr : w_fifo_pr;
`else
            assign w_enq = w_take;
            assign free_q_valid_by_bank[b]             = w_fifo_valid;
            assign free_q_PR_by_bank[b*PR_W +: PR_W]   = w_fifo_pr;
`endif

            rob_pr_free_bank_q #(
                .DEPTH (Q_ENTRIES),
                .W     (PR_W)
            ) u_bank_q (
                .clk        (CLK),
                .rst        (RST),
                .i_enq      (w_enq),
                .i_enq_data (w_sel_pr),
                .i_deq      (free_list_ready_by_bank[b]),
                .o_valid    (w_fifo_valid),
                .o_data     (w_fifo_pr),
                .o_full     (w_fifo_full)
            );
        end
    endgenerate

    always_comb begin
        w_moved = '0;
        for (int i = 0; i < BANKS; i++) begin
            w_moved = w_moved | w_lane_take[i];
        end
    end

    // Ready depends only on registered state; free_list readiness never reaches it.
    assign w_pend_next       = r_pend & ~w_moved;
    assign commit_free_ready = (w_pend_next == '0);
    assign w_accept          = commit_free_ready & (|commit_free_valid_by_way);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_pr[w] <= '0;
            end
        end else if (w_accept) begin
            r_pend <= commit_free_valid_by_way;
            for (int w = 0; w < WAYS; w++) begin
                r_pr[w] <= commit_free_PR_by_way[w*PR_W +: PR_W];
            end
        end else begin
            r_pend <= w_pend_next;
        end
    end

endmodule

`default_nettype wire
